// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing / test-pattern generator.
package vga_pkg;

    // Pattern select encoding
    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    // 640x480@60 defaults (pixel periods / lines)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Width of the pixel / line counters
    localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/vga_pix_ce.sv
// Pixel clock-enable divider: one-dclk pulse every CLK_DIV dclks.
module vga_pix_ce #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic dclk,
    input  logic rst_n,
    output logic pix_ce
);

    generate
        if (CLK_DIV <= 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = dclk ^ rst_n;
            assign pix_ce = 1'b1;
        end else begin : g_div
            localparam int unsigned DW = $clog2(CLK_DIV);
            localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

            logic [DW-1:0] div_q, div_d;

            // Free-running 0..CLK_DIV-1 count
            always_comb div_d = (div_q == LAST) ? '0 : div_q + 1'b1;

            // Divider state register
            always_ff @(posedge dclk or negedge rst_n) begin
                if (!rst_n) div_q <= '0;
                else        div_q <= div_d;
            end

            assign pix_ce = (div_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with selectable internal test patterns.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned R_W      = 3,
    parameter int unsigned G_W      = 3,
    parameter int unsigned B_W      = 2,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CHK_LOG2 = 3
) (
    input  logic             dclk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [R_W-1:0]   i_red,
    input  logic [G_W-1:0]   i_green,
    input  logic [B_W-1:0]   i_blue,
    output logic [9:0]       o_hcount,
    output logic [9:0]       o_vcount,
    output logic             o_req,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [R_W-1:0]   red,
    output logic [G_W-1:0]   green,
    output logic [B_W-1:0]   blue,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             pix_ce;
    logic [CNT_W-1:0] h_q, v_q;
    logic [1:0]       mode_q;
    logic             hsync_q, vsync_q, de_q, frame_start_q;
    logic [7:0]       frame_cnt_q;
    logic [R_W-1:0]   red_q, red_d;
    logic [G_W-1:0]   green_q, green_d;
    logic [B_W-1:0]   blue_q, blue_d;
    logic             req, h_end, wrap, chk;
    logic [2:0]       bar_c;

    // Bar index from elaboration-time edges k*H_ACTIVE/8; returns code 7-k
    function automatic logic [2:0] bar_code(input logic [CNT_W-1:0] h);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i * H_ACTIVE / 8)) k = 3'(i);
        end
        return 3'd7 - k;
    endfunction

    vga_pix_ce #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_ce (
        .dclk   (dclk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce)
    );

    assign req   = (h_q < H_ACT) && (v_q < V_ACT);
    assign h_end = (h_q == H_LAST);
    assign wrap  = pix_ce && h_end && (v_q == V_LAST);
    assign bar_c = bar_code(h_q);
    assign chk   = h_q[CHK_LOG2] ^ v_q[CHK_LOG2];

    // Horizontal / vertical position counters
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (pix_ce) begin
            if (h_end) begin
                h_q <= '0;
                v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    // Colour for the current counter position; blank outside the active area
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (req) begin
            unique case (mode_q)
                MODE_PASS: begin
                    red_d   = i_red;
                    green_d = i_green;
                    blue_d  = i_blue;
                end
                MODE_SOLID: begin
                    red_d   = '1;
                    green_d = '1;
                    blue_d  = '1;
                end
                MODE_BARS: begin
                    red_d   = {R_W{bar_c[2]}};
                    green_d = {G_W{bar_c[1]}};
                    blue_d  = {B_W{bar_c[0]}};
                end
                MODE_CHECK: begin
                    red_d   = {R_W{chk}};
                    green_d = {G_W{chk}};
                    blue_d  = {B_W{chk}};
                end
                default: ;
            endcase
        end
    end

    // Registered sync/colour outputs, frame pulse/count and per-frame mode latch
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            mode_q        <= MODE_PASS;
        end else begin
            frame_start_q <= wrap;
            if (wrap) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                mode_q      <= mode;
            end
            if (pix_ce) begin
                hsync_q <= ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
                vsync_q <= ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
                de_q    <= req;
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
            end
        end
    end

    assign o_hcount    = h_q;
    assign o_vcount    = v_q;
    assign o_req       = req;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Directed scoreboard bench for vga_timing_pattern_gen on a reduced 80x22 raster.
module tb_vga_timing_pattern_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;  // 80
    localparam int VT = VA + VF + VS + VB;  // 22

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic       dclk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [2:0] i_red, i_green;
    logic [1:0] i_blue;
    logic [9:0] o_hcount, o_vcount;
    logic       o_req, hsync, vsync, de, frame_start;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [7:0] frame_cnt;

    // Second build with CLK_DIV=1, used for frame-period comparison only
    logic [9:0] h1, v1;
    logic       req1, hs1, vs1, de1, fs1;
    logic [2:0] r1, g1;
    logic [1:0] b1;
    logic [7:0] fc1;

    int total = 0;
    int bad   = 0;
    int hm, vm;
    logic [1:0] mode_m;
    logic [7:0] fc_m;
    exp_t sb[$];

    int cyc = 0, last0 = 0, last1 = 0, per0 = 0, per1 = 0;

    always #5 dclk = ~dclk;

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(2), .CHK_LOG2(3)
    ) u_dut (
        .dclk(dclk), .rst_n(rst_n), .mode(mode),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_hcount(o_hcount), .o_vcount(o_vcount), .o_req(o_req),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(1), .CHK_LOG2(3)
    ) u_dut_div1 (
        .dclk(dclk), .rst_n(rst_n), .mode(mode),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_hcount(h1), .o_vcount(v1), .o_req(req1),
        .hsync(hs1), .vsync(vs1), .de(de1),
        .red(r1), .green(g1), .blue(b1),
        .frame_start(fs1), .frame_cnt(fc1)
    );

    // dclk count between frame_start pulses for both builds
    always @(posedge dclk) begin
        cyc <= cyc + 1;
        if (frame_start) begin
            per0  <= cyc - last0;
            last0 <= cyc;
        end
        if (fs1) begin
            per1  <= cyc - last1;
            last1 <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic exp_t model(input int h, input int v, input logic [1:0] md,
                                   input logic [2:0] ir, input logic [2:0] ig,
                                   input logic [1:0] ib, input logic fs, input logic [7:0] fc);
        exp_t e;
        logic act, ck;
        logic [2:0] c;
        act  = (h < HA) && (v < VA);
        e    = '0;
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e.de = act;
        e.fs = fs;
        e.fc = fc;
        if (act) begin
            case (md)
                2'd0: begin e.r = ir; e.g = ig; e.b = ib; end
                2'd1: begin e.r = 3'd7; e.g = 3'd7; e.b = 2'd3; end
                2'd2: begin
                    c   = 3'(7 - h / (HA / 8));
                    e.r = {3{c[2]}};
                    e.g = {3{c[1]}};
                    e.b = {2{c[0]}};
                end
                default: begin
                    ck  = 1'((h >> 3) & 1) ^ 1'((v >> 3) & 1);
                    e.r = {3{ck}};
                    e.g = {3{ck}};
                    e.b = {2{ck}};
                end
            endcase
        end
        return e;
    endfunction

    // Entry: #1 after a dclk edge whose following edge carries pix_ce
    task automatic pixel_step();
        exp_t e;
        logic wrap;
        logic [7:0] fc_next;
        check("hcount", 32'(o_hcount), 32'(hm));
        check("vcount", 32'(o_vcount), 32'(vm));
        check("req", 32'(o_req), 32'((hm < HA) && (vm < VA)));
        i_red   = 3'(hm & 7);
        i_green = 3'(vm & 7);
        i_blue  = 2'(hm & 3);
        wrap    = (hm == HT - 1) && (vm == VT - 1);
        fc_next = wrap ? fc_m + 8'd1 : fc_m;
        sb.push_back(model(hm, vm, mode_m, i_red, i_green, i_blue, wrap, fc_next));
        if (wrap) mode_m = mode;
        @(posedge dclk);
        #1;
        e = sb.pop_front();
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
        check("de", 32'(de), 32'(e.de));
        check("red", 32'(red), 32'(e.r));
        check("green", 32'(green), 32'(e.g));
        check("blue", 32'(blue), 32'(e.b));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        fc_m = fc_next;
        if (hm == HT - 1) begin
            hm = 0;
            vm = (vm == VT - 1) ? 0 : vm + 1;
        end else begin
            hm = hm + 1;
        end
        @(posedge dclk);
        #1;
        check("frame_start_1clk", 32'(frame_start), 32'(0));
    endtask

    task automatic check_reset_values();
        check("rst_hcount", 32'(o_hcount), 32'(0));
        check("rst_vcount", 32'(o_vcount), 32'(0));
        check("rst_hsync", 32'(hsync), 32'(1));
        check("rst_vsync", 32'(vsync), 32'(1));
        check("rst_de", 32'(de), 32'(0));
        check("rst_rgb", 32'({red, green, blue}), 32'(0));
        check("rst_frame_start", 32'(frame_start), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    endtask

    task automatic release_reset();
        @(negedge dclk);
        rst_n = 1'b1;
        @(posedge dclk);
        #1;
        hm     = 0;
        vm     = 0;
        mode_m = 2'd0;
        fc_m   = 8'd0;
        sb.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        mode    = 2'd0;
        i_red   = '0;
        i_green = '0;
        i_blue  = '0;
        #12;
        check_reset_values();
        release_reset();

        // Frame 1: passthrough; mode=1 raised on the wrapping pixel itself
        for (int n = 0; n < HT * VT; n++) begin
            if (n == HT * VT - 1) mode = 2'd1;
            pixel_step();
        end

        // Frame 2: solid white; switch to checkerboard at v=10, must not show until next frame
        for (int n = 0; n < HT * VT; n++) begin
            if (n == 10 * HT) mode = 2'd3;
            pixel_step();
        end
        check("period_div2", 32'(per0), 32'(2 * HT * VT));
        check("period_div1", 32'(per1), 32'(HT * VT));

        // Frame 3: checkerboard; bars requested for the next frame
        for (int n = 0; n < HT * VT; n++) begin
            if (n == 3 * HT) mode = 2'd2;
            pixel_step();
        end
        check("period_div2_f3", 32'(per0), 32'(2 * HT * VT));

        // Frame 4: colour bars up to (30,5), then asynchronous reset mid-frame
        for (int n = 0; n < 5 * HT + 30; n++) pixel_step();
        check("pre_rst_hcount", 32'(o_hcount), 32'(30));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        check("rst_req", 32'(o_req), 32'(1));
        repeat (3) @(posedge dclk);
        #1;
        check_reset_values();
        mode = 2'd0;
        release_reset();

        // Counters restart from 0 in passthrough
        for (int n = 0; n < 2 * HT; n++) pixel_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
